// File: rtl/jt51_lfo_pkg.sv
// Shared types and helpers for the multi-channel JT51 LFO: wave codes,
// config selectors, LFSR seed/taps and the phase-increment shift table.
package jt51_lfo_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_SQR = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_NOI = 2'd3
  } wave_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  localparam logic [1:0] SEL_FREQ = 2'd0;
  localparam logic [1:0] SEL_AMD  = 2'd1;
  localparam logic [1:0] SEL_PMD  = 2'd2;
  localparam logic [1:0] SEL_WAVE = 2'd3;

  localparam int         LFSR_W     = 15;
  localparam logic [14:0] LFSR_SEED = 15'h1;
  localparam int         LFSR_TAP_A = 14;
  localparam int         LFSR_TAP_B = 13;

  // 5-bit mantissa shifted by up to 15
  localparam int INC_W = 5 + 15;

  function automatic logic [INC_W-1:0] lfo_inc(input logic [7:0] f);
    return INC_W'({1'b1, f[3:0]}) << f[7:4];
  endfunction

  // x^15 + x^14 + 1, Fibonacci form shifting towards the MSB
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/jt51_lfo_shaper.sv
// Combinational wave shaping and AM/PM depth scaling for one LFO slot.
module jt51_lfo_shaper
  import jt51_lfo_pkg::*;
#(
  parameter int AMW = 7,
  parameter int PMW = 8
) (
  input  logic [7:0]            p,
  input  wave_e                 wave,
  input  logic [7:0]            noise,
  input  logic [AMW-1:0]        amd,
  input  logic [PMW-2:0]        pmd,
  output logic [AMW-1:0]        am,
  output logic signed [PMW-1:0] pm,
  output logic [PMW-1:0]        pm_u
);

  logic [7:0]            w;
  logic [AMW+7:0]        am_prod;
  logic signed [7:0]     s;
  logic signed [PMW+6:0] pm_prod;

  always_comb begin
    w = p;
    case (wave)
      WAVE_SQR: w = p[7] ? 8'hFF : 8'h00;
      WAVE_TRI: w = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      WAVE_NOI: w = noise;
      default:  w = p;
    endcase
  end

  assign am_prod = (AMW+8)'(w) * (AMW+8)'(amd);
  assign am      = AMW'(am_prod >> 8);

  // |s*pmd| < 2^(PMW+6), so PMW+7 signed bits hold the product exactly
  assign s       = $signed(w ^ 8'h80);
  assign pm_prod = (PMW+7)'(s) * (PMW+7)'($signed({1'b0, pmd}));
  assign pm      = PMW'(pm_prod >>> 7);
  assign pm_u    = pm[PMW-1] ? {1'b1, ~pm[PMW-2:0]} : pm;

endmodule

// File: rtl/jt51_lfo_mc.sv
// Time-multiplexed multi-channel LFO: one channel per cen during a sweep.
// Optional feature: define LFO_SYNC_EN for per-channel phase sync via ch_sync.
module jt51_lfo_mc
  import jt51_lfo_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int PHW = 24,
  parameter  int AMW = 7,
  parameter  int PMW = 8,
  localparam int CW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  zero,
  input  logic                  lfo_rst,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_ch,
  input  logic [1:0]            cfg_sel,
  input  logic [7:0]            cfg_din,
  input  logic [NCH-1:0]        ch_sync,
  output logic                  out_vld,
  output logic [CW-1:0]         out_ch,
  output logic [AMW-1:0]        am,
  output logic signed [PMW-1:0] pm,
  output logic [PMW-1:0]        pm_u,
  output logic                  ovr
);

  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  logic [NCH-1:0][7:0]        freq;
  logic [NCH-1:0][AMW-1:0]    amd;
  logic [NCH-1:0][PMW-2:0]    pmd;
  logic [NCH-1:0][1:0]        wave;

  logic [NCH-1:0][PHW-1:0]    phase;
  logic [NCH-1:0][LFSR_W-1:0] lfsr;

  state_e                     state;
  logic [CW-1:0]              slot;
  logic                       proc;
  logic                       sync_hit;

  logic [PHW-1:0]             ph_cur, ph_nxt, inc;
  logic [LFSR_W-1:0]          lf_cur, lf_nxt;
  logic [AMW-1:0]             sh_am;
  logic signed [PMW-1:0]      sh_pm;
  logic [PMW-1:0]             sh_pm_u;

  // Config writes are not gated by cen; the slot reading the same channel
  // in this cycle still sees the registered (old) value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq <= '0;
      amd  <= '0;
      pmd  <= '0;
      wave <= '0;
    end else if (cfg_we) begin
      case (cfg_sel)
        SEL_FREQ: freq[cfg_ch] <= cfg_din;
        SEL_AMD:  amd[cfg_ch]  <= cfg_din[AMW-1:0];
        SEL_PMD:  pmd[cfg_ch]  <= cfg_din[PMW-2:0];
        default:  wave[cfg_ch] <= cfg_din[1:0];
      endcase
    end
  end

  assign proc = cen && (state == ST_SWEEP);

`ifdef LFO_SYNC_EN
  logic [NCH-1:0] sync_lat;

  // A pulse coinciding with its channel's slot is honoured immediately
  assign sync_hit = sync_lat[slot] | ch_sync[slot];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_lat <= '0;
    end else if (lfo_rst) begin
      sync_lat <= '0;
    end else begin
      sync_lat <= sync_lat | ch_sync;
      if (proc) sync_lat[slot] <= 1'b0;
    end
  end
`else
  logic unused_sync;
  assign unused_sync = ^ch_sync;
  assign sync_hit    = 1'b0;
`endif

  always_comb begin
    ph_cur = sync_hit ? '0 : phase[slot];
    lf_cur = sync_hit ? LFSR_SEED : lfsr[slot];
    inc    = PHW'(lfo_inc(freq[slot]));
    ph_nxt = ph_cur + inc;
    lf_nxt = (ph_nxt[PHW-1 -: 8] != ph_cur[PHW-1 -: 8]) ? lfsr_step(lf_cur) : lf_cur;
  end

  // Outputs reflect the channel's phase at the start of its slot
  jt51_lfo_shaper #(.AMW(AMW), .PMW(PMW)) u_shaper (
    .p     (ph_cur[PHW-1 -: 8]),
    .wave  (wave_e'(wave[slot])),
    .noise (lf_cur[7:0]),
    .amd   (amd[slot]),
    .pmd   (pmd[slot]),
    .am    (sh_am),
    .pm    (sh_pm),
    .pm_u  (sh_pm_u)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      lfsr    <= {NCH{LFSR_SEED}};
      state   <= ST_IDLE;
      slot    <= '0;
      out_vld <= 1'b0;
      out_ch  <= '0;
      am      <= '0;
      pm      <= '0;
      pm_u    <= '0;
      ovr     <= 1'b0;
    end else if (lfo_rst) begin
      phase   <= '0;
      lfsr    <= {NCH{LFSR_SEED}};
      state   <= ST_IDLE;
      slot    <= '0;
      out_vld <= 1'b0;
      out_ch  <= '0;
      am      <= '0;
      pm      <= '0;
      pm_u    <= '0;
      ovr     <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      if (cen && state == ST_IDLE && zero) begin
        state <= ST_SWEEP;
        slot  <= '0;
      end
      if (proc) begin
        phase[slot] <= ph_nxt;
        lfsr[slot]  <= lf_nxt;
        out_vld     <= 1'b1;
        out_ch      <= slot;
        am          <= sh_am;
        pm          <= sh_pm;
        pm_u        <= sh_pm_u;
        // A tick landing inside a sweep is dropped but remembered
        if (zero) ovr <= 1'b1;
        if (slot == LAST) begin
          state <= ST_IDLE;
          slot  <= '0;
        end else begin
          slot <= slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt51_lfo_mc.sv
// Scoreboard bench for jt51_lfo_mc: stimulus pushes expected slot results,
// a negedge monitor pops and compares whenever out_vld is seen.
`timescale 1ns/1ps
module tb_jt51_lfo_mc;

  localparam int NCH = 4;
  localparam int PHW = 24;
  localparam int AMW = 7;
  localparam int PMW = 8;
  localparam int CW  = 2;

`ifdef LFO_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, zero = 1'b0, lfo_rst = 1'b0, cfg_we = 1'b0;
  logic [CW-1:0]  cfg_ch  = '0;
  logic [1:0]     cfg_sel = '0;
  logic [7:0]     cfg_din = '0;
  logic [NCH-1:0] ch_sync = '0;
  logic                  out_vld;
  logic [CW-1:0]         out_ch;
  logic [AMW-1:0]        am;
  logic signed [PMW-1:0] pm;
  logic [PMW-1:0]        pm_u;
  logic                  ovr;

  jt51_lfo_mc #(.NCH(NCH), .PHW(PHW), .AMW(AMW), .PMW(PMW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .lfo_rst(lfo_rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_din(cfg_din),
    .ch_sync(ch_sync), .out_vld(out_vld), .out_ch(out_ch), .am(am), .pm(pm),
    .pm_u(pm_u), .ovr(ovr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]  ch;
    logic [AMW-1:0] am;
    logic [PMW-1:0] pm;
    logic [PMW-1:0] pm_u;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   ch1_pm_min = 0, ch1_pm_max = 0, ch2_am_max = 0;

  int unsigned m_ph[NCH];
  logic [14:0] m_lf[NCH];
  logic [7:0]  m_freq[NCH];
  logic [1:0]  m_wave[NCH];
  int          m_amd[NCH], m_pmd[NCH];
  bit          m_sync[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_vld) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: ch %0d am %0h pm %0h with no expected entry", out_ch, am, pm);
      end else begin
        mon_e = q.pop_front();
        check($sformatf("slot_ch%0d {ch,am,pm,pm_u}", mon_e.ch),
              {7'd0, out_ch, am, pm, pm_u}, {7'd0, mon_e});
      end
      if (out_ch == 2'd1) begin
        if (int'(pm) < ch1_pm_min) ch1_pm_min = int'(pm);
        if (int'(pm) > ch1_pm_max) ch1_pm_max = int'(pm);
      end
      if (out_ch == 2'd2 && int'(am) > ch2_am_max) ch2_am_max = int'(am);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] lf_step(input logic [14:0] v);
    return {v[13:0], v[14] ^ v[13]};
  endfunction

  task automatic model_reset_state();
    for (int i = 0; i < NCH; i++) begin
      m_ph[i]   = 0;
      m_lf[i]   = 15'h1;
      m_sync[i] = 1'b0;
    end
  endtask

  task automatic model_cfg(input int c, input logic [1:0] sel, input logic [7:0] din);
    case (sel)
      2'd0:    m_freq[c] = din;
      2'd1:    m_amd[c]  = int'(din & 8'h7F);
      2'd2:    m_pmd[c]  = int'(din & 8'h7F);
      default: m_wave[c] = din[1:0];
    endcase
  endtask

  task automatic cfg(input int c, input logic [1:0] sel, input logic [7:0] din);
    cfg_we = 1'b1; cfg_ch = CW'(c); cfg_sel = sel; cfg_din = din;
    model_cfg(c, sel, din);
    tick();
    cfg_we = 1'b0;
  endtask

  // Expected output for channel c's slot, then advance the model channel
  task automatic slot_exp(input int c);
    int unsigned ph, pn, inc;
    logic [14:0] lf;
    int p, w, am_e, s, pm_e;
    exp_t e;
    ph = m_sync[c] ? 0 : m_ph[c];
    lf = m_sync[c] ? 15'h1 : m_lf[c];
    m_sync[c] = 1'b0;
    p = int'(ph >> 16);
    case (m_wave[c])
      2'd0:    w = p;
      2'd1:    w = (p >= 128) ? 255 : 0;
      2'd2:    w = (p >= 128) ? 255 - ((p * 2) % 256) : (p * 2) % 256;
      default: w = int'(lf[7:0]);
    endcase
    am_e   = (w * m_amd[c]) / 256;
    s      = w - 128;
    pm_e   = (s * m_pmd[c]) >>> 7;
    e.ch   = CW'(c);
    e.am   = AMW'(am_e);
    e.pm   = PMW'(pm_e);
    e.pm_u = (pm_e < 0) ? PMW'(255 - (pm_e & 127)) : PMW'(pm_e);
    q.push_back(e);
    inc = (16 + int'(m_freq[c][3:0])) << m_freq[c][7:4];
    pn  = (ph + inc) % (1 << PHW);
    if ((pn >> 16) != (ph >> 16)) lf = lf_step(lf);
    m_ph[c] = pn;
    m_lf[c] = lf;
  endtask

  // gap: idle cen=0 cycles between slots; inj_slot: cfg write in that slot's cycle;
  // zmid: zero on odd slots; sync_slot: ch_sync pulse in that slot's cycle
  task automatic sweep(input int gap, input int inj_slot, input logic [1:0] isel,
                       input logic [7:0] idin, input bit zmid, input int sync_slot);
    cen = 1'b1; zero = 1'b1;
    tick();
    zero = 1'b0;
    repeat (gap) begin cen = 1'b0; tick(); end
    for (int c = 0; c < NCH; c++) begin
      if (sync_slot == c) begin
        ch_sync[c] = 1'b1;
        if (SYNC) m_sync[c] = 1'b1;
      end
      slot_exp(c);
      if (inj_slot == c) begin
        cfg_we = 1'b1; cfg_ch = CW'(c); cfg_sel = isel; cfg_din = idin;
        model_cfg(c, isel, idin);
      end
      cen  = 1'b1;
      zero = zmid && (c % 2 == 1);
      tick();
      cfg_we = 1'b0; zero = 1'b0; ch_sync = '0;
      repeat (gap) begin cen = 1'b0; tick(); end
    end
    cen = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_freq[i] = 8'h00; m_wave[i] = 2'd0; m_amd[i] = 0; m_pmd[i] = 0;
    end
    model_reset_state();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_out_vld", out_vld, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_am", am, 0);
    check("rst_pm", pm, 0);
    check("rst_pm_u", pm_u, 0);
    check("rst_ovr", ovr, 0);

    sweep(0, -1, 2'd0, 8'h00, 1'b0, -1);

    cfg(0, 2'd0, 8'hF0); cfg(0, 2'd3, 8'h00); cfg(0, 2'd1, 8'd127);
    cfg(1, 2'd0, 8'hFF); cfg(1, 2'd3, 8'h01); cfg(1, 2'd2, 8'd127);
    cfg(2, 2'd0, 8'hF0); cfg(2, 2'd3, 8'h02); cfg(2, 2'd1, 8'd64);
    cfg(3, 2'd0, 8'hC3); cfg(3, 2'd3, 8'h03); cfg(3, 2'd1, 8'd127); cfg(3, 2'd2, 8'd100);
    repeat (34) sweep(0, -1, 2'd0, 8'h00, 1'b0, -1);
    check("tri_am_peak_amd64", ch2_am_max, 63);
    check("sqr_pm_max_pmd127", ch1_pm_max, 126);
    check("sqr_pm_min_pmd127", ch1_pm_min, -127);
    check("ovr_clean_sweeps", ovr, 0);

    repeat (2) sweep(1, -1, 2'd0, 8'h00, 1'b0, -1);

    sweep(0, 2, 2'd0, 8'hFF, 1'b0, -1);
    repeat (2) sweep(0, -1, 2'd0, 8'h00, 1'b0, -1);

    sweep(0, -1, 2'd0, 8'h00, 1'b1, -1);
    cen = 1'b1;
    repeat (6) tick();
    cen = 1'b0;
    check("ovr_set_by_mid_zero", ovr, 1);

    lfo_rst = 1'b1; cen = 1'b1; zero = 1'b1;
    tick();
    lfo_rst = 1'b0; zero = 1'b0;
    model_reset_state();
    check("lforst_ovr", ovr, 0);
    check("lforst_out_vld", out_vld, 0);
    check("lforst_am", am, 0);
    check("lforst_pm", pm, 0);
    repeat (6) tick();
    cen = 1'b0;
    repeat (3) sweep(0, -1, 2'd0, 8'h00, 1'b0, -1);

    cfg(1, 2'd3, 8'h00); cfg(1, 2'd1, 8'd127);
    cen = 1'b1; ch_sync[1] = 1'b1;
    if (SYNC) m_sync[1] = 1'b1;
    tick();
    ch_sync = '0; cen = 1'b0;
    sweep(0, -1, 2'd0, 8'h00, 1'b0, 3);
    repeat (2) sweep(0, -1, 2'd0, 8'h00, 1'b0, -1);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
